// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with valid/ready handshakes and an optional iterative
// unsigned multiply/divide unit, built only when ALU_MDU_EN is defined.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  // Handshake: an op transfers in on a rising edge with in_valid & in_ready, a
  // result transfers out on a rising edge with out_valid & out_ready; valid is
  // never withdrawn before its transfer and the payload is held until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             accept;
  logic             is_mop;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;

  always_comb begin : single_cycle
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op)
      4'b0000: alu_res = op1 & op2;
      4'b0001: alu_res = op1 | op2;
      4'b0010: alu_res = op1 + op2;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'b0101: alu_res = op1 ^ op2;
      4'b0110: alu_res = op1 - op2;
      4'b1000: alu_res = op1 >> op2[SHW-1:0];
      4'b1001: alu_res = op1 << op2[SHW-1:0];
      4'b1010: alu_res = $signed(op1) >>> op2[SHW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MDU_EN
  // acc holds the product high half / partial remainder, lo holds the
  // product low half / dividend-then-quotient; they shift together.
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mop_q, mop_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_acc, step_lo, mdu_res;

  assign is_mop = (alu_op[3:2] == 2'b11);

  always_comb begin : mdu_step
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!mop_q[1]) begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_acc = div_diff[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = div_shift[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign is_mop = 1'b0;
`endif

  always_comb begin : fsm
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    if (state_q == DONE && out_ready) state_d = IDLE;
    if (accept) begin
      if (is_mop) begin
        state_d = BUSY;
      end else begin
        state_d   = DONE;
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = alu_ill;
      end
    end
`ifdef ALU_MDU_EN
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    mdu_res = mop_q[0] ? acc_q : lo_q;
    if (accept && is_mop) begin
      cnt_d  = CW'(WIDTH);
      mop_d  = alu_op[1:0];
      acc_d  = '0;
      lo_d   = alu_op[1] ? op1 : op2;
      opnd_d = alu_op[1] ? op2 : op1;
    end
    if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d   = DONE;
        result_d  = mdu_res;
        zero_d    = (mdu_res == '0);
        illegal_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_MDU_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mop_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mop_q  <= mop_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end
`endif

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;
endmodule
